// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding,
// port identifiers and a small helper used by the grant logic.
package mem_arb_pkg;

  // Access sequencer states, 2-bit encoding
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Requesting port identifiers
  typedef enum logic {
    PORT_FETCH = 1'b0,
    PORT_DATA  = 1'b1
  } port_e;

  // Returns the port that is not p
  function automatic port_e other_port(input port_e p);
    return (p == PORT_DATA) ? PORT_FETCH : PORT_DATA;
  endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational grant selection for the memory arbiter.
// A lone request is granted directly; on contention the port that was not
// granted last wins. The top feeds a constant last_grant when rotation is
// disabled, which turns this rule into fixed data-over-fetch priority.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic  f_req,
  input  logic  d_req,
  input  port_e last_grant,
  output port_e grant
);

  // Pick the port to grant from the current requests and the last winner
  always_comb begin
    grant = PORT_DATA;
    if (f_req && d_req) begin
      grant = other_port(last_grant);
    end else if (f_req) begin
      grant = PORT_FETCH;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single synchronous memory.
// Each access runs IDLE -> ACCESS -> WAIT -> DONE: the strobe is issued in
// ACCESS, read data arrives during WAIT and is captured at the WAIT->DONE
// edge, and the granted port's ack pulses in DONE.
// Optional feature: define ARB_RR_EN to alternate grants under contention
// (last_grant register, reset to DATA); otherwise data has fixed priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic [DW-1:0] f_rdata,
  output logic          f_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data_o,
  input  logic [DW-1:0] mem_data_i,
  output logic          busy
);

  state_e        state_q,      state_d;
  port_e         grant_q,      grant_d;
  logic          wr_q,         wr_d;
  logic          mem_en_q,     mem_en_d;
  logic          mem_we_q,     mem_we_d;
  logic [AW-1:0] mem_addr_q,   mem_addr_d;
  logic [DW-1:0] mem_data_o_q, mem_data_o_d;
  logic [DW-1:0] f_rdata_q,    f_rdata_d;
  logic [DW-1:0] d_rdata_q,    d_rdata_d;
  logic          f_ack_q,      f_ack_d;
  logic          d_ack_q,      d_ack_d;
  logic          busy_q,       busy_d;

  port_e         pick;
  port_e         pick_last;

`ifdef ARB_RR_EN
  port_e         last_grant_q, last_grant_d;
  assign pick_last = last_grant_q;
`else
  // A constant FETCH as "last winner" makes data win every contention
  assign pick_last = PORT_FETCH;
`endif

  arb_pick u_pick (
    .f_req      (f_req),
    .d_req      (d_req),
    .last_grant (pick_last),
    .grant      (pick)
  );

  // Next-state and next-output computation for the access sequencer
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    wr_d         = wr_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_data_o_d = mem_data_o_q;
    f_rdata_d    = f_rdata_q;
    d_rdata_d    = d_rdata_q;
    f_ack_d      = 1'b0;
    d_ack_d      = 1'b0;
    busy_d       = busy_q;
`ifdef ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (f_req || d_req) begin
          state_d  = ACCESS;
          grant_d  = pick;
          mem_en_d = 1'b1;
          busy_d   = 1'b1;
`ifdef ARB_RR_EN
          last_grant_d = pick;
`endif
          if (pick == PORT_DATA) begin
            mem_addr_d   = d_addr;
            mem_we_d     = d_we;
            wr_d         = d_we;
            mem_data_o_d = d_wdata;
          end else begin
            mem_addr_d   = f_addr;
            wr_d         = 1'b0;
          end
        end
      end
      ACCESS: begin
        state_d = WAIT;
      end
      WAIT: begin
        state_d = DONE;
        if (grant_q == PORT_DATA) begin
          d_ack_d = 1'b1;
          if (!wr_q) begin
            d_rdata_d = mem_data_i;
          end
        end else begin
          f_ack_d   = 1'b1;
          f_rdata_d = mem_data_i;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Register FSM state and all outputs; reset clears them immediately
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= IDLE;
      grant_q      <= PORT_DATA;
      wr_q         <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_o_q <= '0;
      f_rdata_q    <= '0;
      d_rdata_q    <= '0;
      f_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      busy_q       <= 1'b0;
`ifdef ARB_RR_EN
      last_grant_q <= PORT_DATA;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      wr_q         <= wr_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_o_q <= mem_data_o_d;
      f_rdata_q    <= f_rdata_d;
      d_rdata_q    <= d_rdata_d;
      f_ack_q      <= f_ack_d;
      d_ack_q      <= d_ack_d;
      busy_q       <= busy_d;
`ifdef ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data_o = mem_data_o_q;
  assign f_rdata    = f_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign f_ack      = f_ack_q;
  assign d_ack      = d_ack_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a small synchronous memory model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk;
  logic          arst_n;
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic [DW-1:0] f_rdata;
  logic          f_ack;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_o;
  logic [DW-1:0] mem_data_i;
  logic          busy;

  logic [DW-1:0] mem [0:255];

  int checks;
  int failures;
  bit first_data;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .f_req      (f_req),
    .f_addr     (f_addr),
    .f_rdata    (f_rdata),
    .f_ack      (f_ack),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_ack      (d_ack),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_data_o (mem_data_o),
    .mem_data_i (mem_data_i),
    .busy       (busy)
  );

  // Free-running clock, 10 time units per cycle
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous memory: read data appears the cycle after the strobe
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr] <= mem_data_o;
      end
      mem_data_i <= mem[mem_addr];
    end
  end

  task automatic applyStimulus(input logic fr, input logic [AW-1:0] fa,
                               input logic dr, input logic dw,
                               input logic [AW-1:0] da, input logic [DW-1:0] dd);
    f_req   = fr;
    f_addr  = fa;
    d_req   = dr;
    d_we    = dw;
    d_addr  = da;
    d_wdata = dd;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    mem_data_i = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h10] = 8'hA5;
    mem[8'h20] = 8'h5A;
    mem[8'h40] = 8'h77;
    arst_n = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);

    // Reset state
    tick(1);
    checkOutput("rst_busy",   busy,       0);
    checkOutput("rst_mem_en", mem_en,     0);
    checkOutput("rst_mem_we", mem_we,     0);
    checkOutput("rst_acks",   {f_ack, d_ack}, 0);
    checkOutput("rst_addr",   mem_addr,   0);
    checkOutput("rst_wdata",  mem_data_o, 0);
    checkOutput("rst_rdata",  {f_rdata, d_rdata}, 0);
    arst_n = 1'b1;
    tick(1);

    // Single fetch read of 0x10
    applyStimulus(1'b1, 8'h10, 1'b0, 1'b0, '0, '0);
    tick(1);
    checkOutput("f1_mem_en",  mem_en,   1);
    checkOutput("f1_mem_we",  mem_we,   0);
    checkOutput("f1_addr",    mem_addr, 8'h10);
    checkOutput("f1_busy",    busy,     1);
    checkOutput("f1_ack_n1",  f_ack,    0);
    tick(1);
    checkOutput("f1_en_n2",   mem_en,   0);
    checkOutput("f1_ack_n2",  f_ack,    0);
    tick(1);
    checkOutput("f1_ack",     f_ack,    1);
    checkOutput("f1_dack",    d_ack,    0);
    checkOutput("f1_rdata",   f_rdata,  8'hA5);
    f_req = 1'b0;
    tick(1);
    checkOutput("f1_ack_off", f_ack,    0);
    checkOutput("f1_idle",    busy,     0);

    // Data write of 0x3C to 0x80
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 8'h80, 8'h3C);
    tick(1);
    checkOutput("dw_mem_en",  mem_en,     1);
    checkOutput("dw_mem_we",  mem_we,     1);
    checkOutput("dw_addr",    mem_addr,   8'h80);
    checkOutput("dw_wdata",   mem_data_o, 8'h3C);
    tick(1);
    checkOutput("dw_we_n2",   mem_we,     0);
    checkOutput("dw_hold",    {mem_addr, mem_data_o}, 16'h803C);
    tick(1);
    checkOutput("dw_ack",     d_ack,      1);
    checkOutput("dw_fack",    f_ack,      0);
    checkOutput("dw_drdata",  d_rdata,    0);
    checkOutput("dw_frdata",  f_rdata,    8'hA5);
    d_req = 1'b0;
    tick(1);

    // Data read back from 0x80
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 8'h80, 8'hFF);
    tick(1);
    checkOutput("dr_mem_we",  mem_we,  0);
    tick(2);
    checkOutput("dr_ack",     d_ack,   1);
    checkOutput("dr_drdata",  d_rdata, 8'h3C);
    checkOutput("dr_frdata",  f_rdata, 8'hA5);
    d_req = 1'b0;
    tick(1);

    // Contention rounds with both requests held
`ifdef ARB_RR_EN
    first_data = 1'b0;
`else
    first_data = 1'b1;
`endif
    for (int r = 0; r < 2; r++) begin
      applyStimulus(1'b1, 8'h20, 1'b1, 1'b0, 8'h40, 8'h00);
      tick(1);
      checkOutput("c_first_addr", mem_addr, first_data ? 8'h40 : 8'h20);
      tick(2);
      checkOutput("c_first_acks", {f_ack, d_ack}, first_data ? 2'b01 : 2'b10);
      if (first_data) d_req = 1'b0; else f_req = 1'b0;
      tick(1);
      checkOutput("c_gap_acks", {f_ack, d_ack}, 2'b00);
      tick(1);
      checkOutput("c_second_addr", mem_addr, first_data ? 8'h20 : 8'h40);
      checkOutput("c_second_en",   mem_en,   1);
      tick(2);
      checkOutput("c_second_acks", {f_ack, d_ack}, first_data ? 2'b10 : 2'b01);
      checkOutput("c_rdata", {f_rdata, d_rdata}, 16'h5A77);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
      tick(1);
      checkOutput("c_idle", busy, 0);
    end

    // Reset asserted during WAIT aborts the access
    applyStimulus(1'b1, 8'h10, 1'b0, 1'b0, '0, '0);
    tick(2);
    checkOutput("ra_busy_wait", busy, 1);
    arst_n = 1'b0;
    #1;
    checkOutput("ra_busy",  busy,     0);
    checkOutput("ra_addr",  mem_addr, 0);
    checkOutput("ra_rdata", {f_rdata, d_rdata}, 0);
    f_req = 1'b0;
    tick(1);
    checkOutput("ra_ack_held", {f_ack, d_ack}, 0);
    arst_n = 1'b1;
    tick(1);
    checkOutput("ra_ack_after1", {f_ack, d_ack, busy}, 0);
    tick(2);
    checkOutput("ra_ack_after3", {f_ack, d_ack, busy}, 0);
    applyStimulus(1'b1, 8'h20, 1'b0, 1'b0, '0, '0);
    tick(3);
    checkOutput("ra_next_ack",   f_ack,   1);
    checkOutput("ra_next_rdata", f_rdata, 8'h5A);
    f_req = 1'b0;
    tick(1);

    // Fetch request withdrawn during ACCESS still completes
    applyStimulus(1'b1, 8'h10, 1'b0, 1'b0, '0, '0);
    tick(1);
    f_req = 1'b0;
    checkOutput("wd_mem_en", mem_en, 1);
    tick(2);
    checkOutput("wd_ack",    f_ack,   1);
    checkOutput("wd_rdata",  f_rdata, 8'hA5);
    tick(1);
    checkOutput("wd_ack_off", {f_ack, busy}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
